// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the pipelined RV32I control path.
//   ctrl_bundle_t : full control bundle produced by decode and held in E
//   mem_bundle_t  : the subset of the bundle that still matters from M onward
//   CTRL_BUBBLE / MEM_BUBBLE : all-zero bundles (no writes, no redirects)
// Optional feature macro: RV_MEXT_EN (M-extension ALU codes 16..23, ALUControl 5 bits wide).
package ctrl_pkg;

`ifdef RV_MEXT_EN
  localparam int ALUC_PW = 5;
`else
  localparam int ALUC_PW = 4;
`endif

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // Stored 5 bits wide internally; the top truncates to ALUC_W.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_LUI  = 5'd10,
    ALU_MUL  = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV  = 5'd20, ALU_DIVU = 5'd21, ALU_REM  = 5'd22, ALU_REMU  = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pcsrc_e;
  typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JAL = 2'd1, JMP_JALR = 2'd2} jump_e;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        branch;
    jump_e       jump;
    alu_op_e     alu_op;
    logic        alu_src_a;   // 1: PC
    logic        alu_src_b;   // 1: immediate
    logic [2:0]  funct3;      // branch condition / load-store width
    logic        illegal;
  } ctrl_bundle_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        illegal;
  } mem_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  localparam mem_bundle_t  MEM_BUBBLE  = '0;

  // Base-ISA ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/main_decoder.sv
// main_decoder: combinational RV32I decode of one instruction word.
//   i_instr   : instruction in D
//   o_ctrl    : control bundle (bubble with illegal=1 for unsupported encodings)
//   o_imm_src : immediate format (I=0 S=1 B=2 J=3 U=4)
//   o_illegal : encoding not supported
// Optional feature macro: RV_MEXT_EN (funct7=0000001 on OP decodes MUL..REMU).
module main_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl,
  output logic [2:0]   o_imm_src,
  output logic         o_illegal
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_unused;

  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};  // register fields belong to the datapath

  always_comb begin
    ctrl_bundle_t c;
    logic         ill;
    logic [2:0]   imm;
    c   = CTRL_BUBBLE;
    ill = 1'b0;
    imm = IMM_I;
    case (w_op)
      OP_REG: begin
        c.reg_write = 1'b1;
        if (w_f7 == 7'b0000000)
          c.alu_op = alu_from_f3(w_f3, 1'b0);
        else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))
          c.alu_op = alu_from_f3(w_f3, 1'b1);
`ifdef RV_MEXT_EN
        else if (w_f7 == 7'b0000001)
          c.alu_op = alu_op_e'({2'b10, w_f3});
`endif
        else
          ill = 1'b1;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        if (w_f3 == 3'b001)
          ill = (w_f7 != 7'b0000000);
        if (w_f3 == 3'b101)
          ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
        // Shifts use funct7[5] as the arithmetic flag; other I-ops never do.
        c.alu_op = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
      end
      OP_LOAD: begin
        ill          = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
        c.reg_write  = 1'b1;
        c.result_src = RES_MEM;
        c.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        ill         = (w_f3 > 3'b010);
        c.mem_write = 1'b1;
        c.alu_src_b = 1'b1;
        imm         = IMM_S;
      end
      OP_BRANCH: begin
        ill      = (w_f3[2:1] == 2'b01);
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
        imm      = IMM_B;
      end
      OP_JAL: begin
        c.reg_write  = 1'b1;
        c.jump       = JMP_JAL;
        c.result_src = RES_PC4;
        imm          = IMM_J;
      end
      OP_JALR: begin
        ill          = (w_f3 != 3'b000);
        c.reg_write  = 1'b1;
        c.jump       = JMP_JALR;
        c.result_src = RES_PC4;
        c.alu_src_b  = 1'b1;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_LUI;
        c.alu_src_b = 1'b1;
        imm         = IMM_U;
      end
      OP_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 1'b1;
        imm         = IMM_U;
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      c         = CTRL_BUBBLE;
      c.illegal = 1'b1;
      imm       = IMM_I;
    end else begin
      c.funct3  = w_f3;
    end

    o_ctrl    = c;
    o_imm_src = imm;
    o_illegal = ill;
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: pipelined RV32I control path (D decode, E/M/W control registers).
//   clk, rst_n           : clock, async active-low reset
//   InstrD               : instruction in D
//   StallE, FlushE       : hazard-unit hold / bubble for the E register
//   ZeroE, LtE, LtuE     : ALU compare flags for the E instruction
//   ImmSrcD, IllegalD    : combinational decode outputs
//   *E                   : E-stage control, PCSrcE redirect to fetch
//   *M                   : last M slot (MEM_LAT slots deep)
//   *W, IllegalW         : writeback control, sticky illegal flag
// Optional feature macro: RV_MEXT_EN (requires ALUC_W = 5).
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ALUC_W  = ALUC_PW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       InstrD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ZeroE,
  input  logic              LtE,
  input  logic              LtuE,
  output logic [2:0]        ImmSrcD,
  output logic              IllegalD,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic [1:0]        ResultSrcE,
  output logic              RegWriteE,
  output logic [1:0]        PCSrcE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [2:0]        AddressingControlM,
  output logic [1:0]        ResultSrcM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic              IllegalW
);

  ctrl_bundle_t w_ctrl_d;
  ctrl_bundle_t r_e;
  mem_bundle_t  w_m_in;
  mem_bundle_t  r_m [MEM_LAT];
  logic         r_w_reg_write;
  result_src_e  r_w_result_src;
  logic         r_illw;
  logic         w_taken;
  pcsrc_e       w_pcsrc;

  main_decoder u_dec (
    .i_instr   (InstrD),
    .o_ctrl    (w_ctrl_d),
    .o_imm_src (ImmSrcD),
    .o_illegal (IllegalD)
  );

  // D->E: flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_e <= CTRL_BUBBLE;
    else if (FlushE) r_e <= CTRL_BUBBLE;
    else if (!StallE) r_e <= w_ctrl_d;
  end

  // A held or flushed E instruction must not leak into M more than once.
  always_comb begin
    w_m_in = '{reg_write:  r_e.reg_write,
               result_src: r_e.result_src,
               mem_write:  r_e.mem_write,
               funct3:     r_e.funct3,
               illegal:    r_e.illegal};
    if (StallE || FlushE) w_m_in = MEM_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) r_m[i] <= MEM_BUBBLE;
    end else begin
      r_m[0] <= w_m_in;
      for (int i = 1; i < MEM_LAT; i++) r_m[i] <= r_m[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= RES_ALU;
      r_illw         <= 1'b0;
    end else begin
      r_w_reg_write  <= r_m[MEM_LAT-1].reg_write;
      r_w_result_src <= r_m[MEM_LAT-1].result_src;
      r_illw         <= r_illw | r_m[MEM_LAT-1].illegal;
    end
  end

  // Branch resolution. A bubble has branch=0/jump=NONE, so it never redirects.
  always_comb begin
    case (r_e.funct3)
      3'b000:  w_taken = ZeroE;
      3'b001:  w_taken = !ZeroE;
      3'b100:  w_taken = LtE;
      3'b101:  w_taken = !LtE;
      3'b110:  w_taken = LtuE;
      3'b111:  w_taken = !LtuE;
      default: w_taken = 1'b0;
    endcase
    w_pcsrc = PC_PLUS4;
    if (!StallE) begin
      if (r_e.jump == JMP_JALR)
        w_pcsrc = PC_ALU;
      else if (r_e.jump == JMP_JAL || (r_e.branch && w_taken))
        w_pcsrc = PC_IMM;
    end
  end

  assign ALUControlE        = ALUC_W'(r_e.alu_op);
  assign ALUSrcAE           = r_e.alu_src_a;
  assign ALUSrcBE           = r_e.alu_src_b;
  assign ResultSrcE         = r_e.result_src;
  assign RegWriteE          = r_e.reg_write;
  assign PCSrcE             = w_pcsrc;
  assign RegWriteM          = r_m[MEM_LAT-1].reg_write;
  assign MemWriteM          = r_m[MEM_LAT-1].mem_write;
  assign AddressingControlM = r_m[MEM_LAT-1].funct3;
  assign ResultSrcM         = r_m[MEM_LAT-1].result_src;
  assign RegWriteW          = r_w_reg_write;
  assign ResultSrcW         = r_w_result_src;
  assign IllegalW           = r_illw;

endmodule
